// File: rtl/weight_seq_pkg.sv
// weight_seq_pkg: shared widths, memory depth and FSM state type for the weight fetch sequencer
package weight_seq_pkg;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int DIM_W = 10;
  localparam int DEPTH = 3921;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
endpackage

// File: rtl/weight_seq_rc_counter.sv
// weight_seq_rc_counter: row-major row/column counter with latched dimensions, advance and terminal flags
module weight_seq_rc_counter #(
  parameter int DIM_W = weight_seq_pkg::DIM_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             adv,
  input  logic [DIM_W-1:0] rows,
  input  logic [DIM_W-1:0] cols,
  output logic [DIM_W-1:0] row,
  output logic [DIM_W-1:0] col,
  output logic             last_col,
  output logic             last,
  output logic             empty
);
  import weight_seq_pkg::*;
  logic [DIM_W-1:0] nr, nc;
  always_ff @(posedge clk) begin
    if (rst) begin
      nr <= '0;
      nc <= '0;
      row <= '0;
      col <= '0;
    end else if (load) begin
      nr <= rows;
      nc <= cols;
      row <= '0;
      col <= '0;
    end else if (adv) begin
      col <= last_col ? '0 : col + DIM_W'(1);
      row <= last_col ? row + DIM_W'(1) : row;
    end
  end
  assign last_col = col == nc - DIM_W'(1);
  assign last = last_col && row == nr - DIM_W'(1);
  assign empty = nr == '0 || nc == '0;
endmodule

// File: rtl/weight_fetch_sequencer.sv
// weight_fetch_sequencer: streams a row-major weight block from memory over valid/ready; bounds check under WEIGHT_SEQ_BOUNDS_CHECK_EN
module weight_fetch_sequencer #(
  parameter int ADDR_W = weight_seq_pkg::ADDR_W,
  parameter int DATA_W = weight_seq_pkg::DATA_W,
  parameter int DEPTH = weight_seq_pkg::DEPTH,
  parameter int DIM_W = weight_seq_pkg::DIM_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [DIM_W-1:0]  num_rows,
  input  logic [DIM_W-1:0]  num_cols,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [DATA_W-1:0] w_data,
  output logic [DIM_W-1:0]  w_row,
  output logic [DIM_W-1:0]  w_col,
  output logic              w_last_col,
  output logic              w_last,
  output logic              busy,
  output logic              done,
  output logic              err
);
  import weight_seq_pkg::*;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [DIM_W-1:0] row, col;
  logic last_col, last, empty, oob, take, load;
`ifdef WEIGHT_SEQ_BOUNDS_CHECK_EN
  localparam int EW = ADDR_W + 2 * DIM_W;
  logic [EW-1:0] end_addr;
  logic err_q;
  assign end_addr = EW'(base_addr) + EW'(num_rows) * EW'(num_cols);
  assign oob = end_addr > EW'(DEPTH);
  always_ff @(posedge clk) err_q <= !rst && state == IDLE && start && oob;
  assign err = err_q;
`else
  assign oob = 1'b0;
  assign err = 1'b0;
`endif
  assign take = state == IDLE && start && !oob;
  assign load = state == RUN && !empty && (!w_valid || w_ready);
  weight_seq_rc_counter #(.DIM_W(DIM_W)) u_rc (
    .clk(clk), .rst(rst), .load(take), .adv(load), .rows(num_rows), .cols(num_cols),
    .row(row), .col(col), .last_col(last_col), .last(last), .empty(empty)
  );
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (take ? RUN : IDLE)
            : state == RUN ? (empty ? DONE : (load && last) ? FLUSH : RUN)
            : state == FLUSH ? ((w_valid && w_ready) ? DONE : FLUSH)
            : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      addr <= '0;
      w_valid <= 1'b0;
      w_data <= '0;
      w_row <= '0;
      w_col <= '0;
      w_last_col <= 1'b0;
      w_last <= 1'b0;
    end else begin
      if (take) addr <= base_addr;
      else if (load) addr <= addr + ADDR_W'(1);
      if (load) begin
        w_valid <= 1'b1;
        w_data <= mem_data;
        w_row <= row;
        w_col <= col;
        w_last_col <= last_col;
        w_last <= last;
      end else if (w_ready) w_valid <= 1'b0;
    end
  end
  assign mem_addr = addr;
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// tb_weight_fetch_sequencer: scoreboard bench with directed transfers for weight_fetch_sequencer
module tb_weight_fetch_sequencer;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, w_ready = 1'b0;
  logic [15:0] base_addr = '0, mem_addr;
  logic [9:0] num_rows = '0, num_cols = '0, w_row, w_col;
  logic [31:0] mem_data, w_data;
  logic w_valid, w_last_col, w_last, busy, done, err;
  int vectors = 0, errs = 0;
  typedef struct {
    logic [15:0] a;
    logic [9:0] r;
    logic [9:0] c;
    logic lc;
    logic l;
  } exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  assign mem_data = {~mem_addr, mem_addr};
  weight_fetch_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_rows(num_rows),
    .num_cols(num_cols), .mem_addr(mem_addr), .mem_data(mem_data), .w_valid(w_valid),
    .w_ready(w_ready), .w_data(w_data), .w_row(w_row), .w_col(w_col),
    .w_last_col(w_last_col), .w_last(w_last), .busy(busy), .done(done), .err(err)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_ctl"}, {w_valid, busy, done, err, w_last_col, w_last, mem_addr}, '0);
    chk({tag, "_data"}, {w_data, w_row, w_col}, '0);
  endtask
  always @(negedge clk) begin
    if (w_valid === 1'b1 && w_ready === 1'b1) begin
      if (q.size() == 0) chk("unexpected_weight", {w_row, w_col}, '1);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("weight", {w_data, w_row, w_col, w_last_col, w_last},
            {~e.a, e.a, e.r, e.c, e.lc, e.l});
      end
    end
  end
  task automatic run_xfer(input logic [15:0] base, input logic [9:0] rows, input logic [9:0] cols,
                          input bit stall, input bit poke, input int exp_done);
    int n, k, cyc;
    bit st;
    logic [53:0] held;
    logic [15:0] ha;
    exp_t e;
    n = int'(rows) * int'(cols);
    k = 0;
    for (int r = 0; r < int'(rows); r++)
      for (int c = 0; c < int'(cols); c++) begin
        e.a = base + 16'(k);
        e.r = 10'(r);
        e.c = 10'(c);
        e.lc = c == int'(cols) - 1;
        e.l = k == n - 1;
        q.push_back(e);
        k++;
      end
    base_addr = base;
    num_rows = rows;
    num_cols = cols;
    start = 1'b1;
    w_ready = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1;
    chk("busy_run", busy, 1);
    chk("addr_first", mem_addr, base);
    while (!done && cyc < 300) begin
      w_ready = stall ? ((cyc - 1) % 4 == 0 || (cyc - 1) % 4 == 3) : 1'b1;
      if (poke && cyc == 3) begin
        start = 1'b1;
        base_addr = 16'd100;
        num_rows = 10'd1;
        num_cols = 10'd1;
      end
      st = w_valid && !w_ready;
      held = {w_data, w_row, w_col, w_last_col, w_last};
      ha = mem_addr;
      tick();
      cyc++;
      start = 1'b0;
      base_addr = base;
      num_rows = rows;
      num_cols = cols;
      if (st) begin
        chk("stall_hold", {w_data, w_row, w_col, w_last_col, w_last}, held);
        chk("stall_addr", mem_addr, ha);
      end
      if (n == 0) chk("no_valid", w_valid, 0);
    end
    chk("done", done, 1);
    if (exp_done > 0) chk("done_cycle", cyc, exp_done);
    chk("err_quiet", err, 0);
    chk("q_drained", q.size(), 0);
    tick();
    chk("done_pulse", done, 0);
    chk("busy_off", busy, 0);
  endtask
  initial begin
    int guard;
    tick();
    tick();
    check_reset("reset");
    rst = 1'b0;
    tick();
    run_xfer(16'd0, 10'd2, 10'd3, 1'b0, 1'b0, 8);
    run_xfer(16'd20, 10'd2, 10'd3, 1'b1, 1'b0, 0);
    run_xfer(16'd0, 10'd0, 10'd5, 1'b0, 1'b0, 2);
    run_xfer(16'd40, 10'd2, 10'd3, 1'b0, 1'b1, 8);
    for (int k = 0; k < 4; k++) q.push_back('{16'(k), 10'd0, 10'(k), 1'b0, 1'b0});
    base_addr = 16'd0;
    num_rows = 10'd784;
    num_cols = 10'd5;
    start = 1'b1;
    w_ready = 1'b1;
    tick();
    start = 1'b0;
    guard = 0;
    while (!(w_valid && w_col == 10'd3) && guard < 20) begin
      tick();
      guard++;
    end
    chk("reach_elem3", guard < 20, 1);
    rst = 1'b1;
    tick();
    check_reset("midrst");
    chk("midrst_q", q.size(), 0);
    rst = 1'b0;
    tick();
    run_xfer(16'd3915, 10'd1, 10'd5, 1'b0, 1'b0, 7);
`ifdef WEIGHT_SEQ_BOUNDS_CHECK_EN
    base_addr = 16'd3900;
    num_rows = 10'd1;
    num_cols = 10'd30;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("oob_err", {err, busy}, 2'b10);
    tick();
    chk("oob_after", {err, busy, done, w_valid}, 4'b0000);
    run_xfer(16'd3916, 10'd1, 10'd5, 1'b0, 1'b0, 7);
`else
    run_xfer(16'hFFFE, 10'd1, 10'd4, 1'b0, 1'b0, 6);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
